ir_line_tracker: RTL and testbench

Consumes the debounced, blanked IR line-sensor outputs (lftIR, cntrIR, rghtIR) from the IR sensor interface. Counts center-sensor line crossings to determine when a commanded N-square move is complete. Produces a signed heading nudge from the side sensors while a move is in progress. Sits between the IR interface and the command processor / heading PID; move_done feeds the command sequencer and nudge feeds the heading-error adder.

---
 rtl/ir_line_tracker.sv | 192 +++++++++++++++++++
 tb/tb_ir_line_tracker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_line_tracker.sv
// ============================================================================
// Module   : ir_line_tracker
// Purpose  : Counts centre-sensor line crossings to finish an N-square move
//            (two crossings per square) and drives a signed heading nudge
//            from the side sensors while the move is in progress.
// Options  : IR_NUDGE_HOLD_EN - when defined, a nonzero nudge is stretched
//            for NUDGE_HOLD cycles after its side condition drops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_line_tracker #(
  parameter logic signed [11:0] NUDGE_MAG  = 12'sd96,
  parameter int                 TMO_W      = 24,
  parameter int                 SETTLE_CYC = 16,
  parameter int                 NUDGE_HOLD = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lftIR,
  input  logic        cntrIR,
  input  logic        rghtIR,
  input  logic        strt_move,
  input  logic [2:0]  num_sqrs,
  input  logic        abort,
  output logic        moving,
  output logic        move_done,
  output logic [3:0]  lines_crossed,
  output logic [11:0] nudge,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  // Expiry is taken on the edge where the counter would become all-ones.
  localparam logic [TMO_W-1:0] c_WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam int               c_SET_W     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [c_SET_W-1:0] c_SET_LAST = c_SET_W'(SETTLE_CYC - 1);

  state_t             r_state, w_next;
  logic               r_cntr_ff;
  logic [TMO_W-1:0]   r_wdog, w_wdog_nxt;
  logic [c_SET_W-1:0] r_settle, w_settle_nxt;
  logic [3:0]         r_target, w_target_nxt;
  logic [3:0]         r_lines, w_lines_nxt;
  logic [3:0]         w_lines_inc;
  logic               r_moving;
  logic               r_done, w_done_nxt;
  logic               r_tmo, w_tmo_nxt;
  logic signed [11:0] r_nudge;
  logic signed [11:0] w_side;
  logic               w_rise;

  assign w_rise      = cntrIR & ~r_cntr_ff;
  assign w_lines_inc = r_lines + 4'd1;

  // Single-side sensor decode; both or neither gives no correction.
  assign w_side = (lftIR & ~rghtIR) ? NUDGE_MAG :
                  (rghtIR & ~lftIR) ? -NUDGE_MAG : 12'sd0;

  // Next-state and datapath updates for the move sequencer.
  always_comb begin
    w_next       = r_state;
    w_wdog_nxt   = r_wdog;
    w_settle_nxt = r_settle;
    w_target_nxt = r_target;
    w_lines_nxt  = r_lines;
    w_done_nxt   = 1'b0;
    w_tmo_nxt    = r_tmo;
    case (r_state)
      S_IDLE: begin
        if (strt_move) begin
          if (num_sqrs != 3'd0) begin
            w_target_nxt = {num_sqrs, 1'b0};
            w_lines_nxt  = 4'd0;
            w_wdog_nxt   = '0;
            w_tmo_nxt    = 1'b0;
            w_next       = S_MOVE;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_MOVE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_rise) begin
          w_lines_nxt = w_lines_inc;
          w_wdog_nxt  = '0;
          if (w_lines_inc == r_target) begin
            w_settle_nxt = '0;
            w_next       = S_SETTLE;
          end
        end else if (r_wdog == c_WDOG_LAST) begin
          w_wdog_nxt = r_wdog + 1'b1;
          w_tmo_nxt  = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_wdog_nxt = r_wdog + 1'b1;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (r_settle == c_SET_LAST) begin
          w_done_nxt = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_settle_nxt = r_settle + 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; moving tracks the state it is registered with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cntr_ff <= 1'b0;
      r_wdog    <= '0;
      r_settle  <= '0;
      r_target  <= 4'd0;
      r_lines   <= 4'd0;
      r_moving  <= 1'b0;
      r_done    <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cntr_ff <= cntrIR;
      r_wdog    <= w_wdog_nxt;
      r_settle  <= w_settle_nxt;
      r_target  <= w_target_nxt;
      r_lines   <= w_lines_nxt;
      r_moving  <= (w_next == S_MOVE) || (w_next == S_SETTLE);
      r_done    <= w_done_nxt;
      r_tmo     <= w_tmo_nxt;
    end
  end

`ifdef IR_NUDGE_HOLD_EN
  localparam int                 c_HOLD_W    = $clog2(NUDGE_HOLD + 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(NUDGE_HOLD);

  logic [c_HOLD_W-1:0] r_hold;

  // Nudge with stretching: a fresh single-side value reloads the hold, otherwise the last value persists until the hold runs out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nudge <= 12'sd0;
      r_hold  <= '0;
    end else if (w_next != S_MOVE) begin
      r_nudge <= 12'sd0;
      r_hold  <= '0;
    end else if (w_side != 12'sd0) begin
      r_nudge <= w_side;
      r_hold  <= c_HOLD_INIT;
    end else if (r_hold != '0) begin
      r_hold  <= r_hold - 1'b1;
    end else begin
      r_nudge <= 12'sd0;
    end
  end
`else
  logic w_unused_hold;
  assign w_unused_hold = (NUDGE_HOLD > 0);

  // Nudge follows the side sensors with one cycle of latency, only while moving toward the line target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nudge <= 12'sd0;
    end else begin
      r_nudge <= (w_next == S_MOVE) ? w_side : 12'sd0;
    end
  end
`endif

  assign moving        = r_moving;
  assign move_done     = r_done;
  assign lines_crossed = r_lines;
  assign nudge         = r_nudge;
  assign timeout       = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_ir_line_tracker.sv
// ============================================================================
// Module   : tb_ir_line_tracker
// Purpose  : Self-checking bench for ir_line_tracker (short watchdog build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ir_line_tracker;

  localparam int TMO_W = 10;  // expiry 1023 cycles after the last rise

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lftIR = 1'b0, cntrIR = 1'b0, rghtIR = 1'b0;
  logic        strt_move = 1'b0, abort = 1'b0;
  logic [2:0]  num_sqrs = 3'd0;
  logic        moving, move_done, timeout;
  logic [3:0]  lines_crossed;
  logic [11:0] nudge;

  ir_line_tracker #(
    .NUDGE_MAG (12'sd96),
    .TMO_W     (TMO_W),
    .SETTLE_CYC(16),
    .NUDGE_HOLD(256)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lftIR        (lftIR),
    .cntrIR       (cntrIR),
    .rghtIR       (rghtIR),
    .strt_move    (strt_move),
    .num_sqrs     (num_sqrs),
    .abort        (abort),
    .moving       (moving),
    .move_done    (move_done),
    .lines_crossed(lines_crossed),
    .nudge        (nudge),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    int    lines;   // -1 = not checked
    bit    mov;
    bit    done;
    bit    tmo;
    int    nud;
  } exp_t;

  typedef struct {
    bit l;
    bit r;
    int nd;   // expected nudge, plain build
    int nh;   // expected nudge, hold build
  } nrow_t;

  exp_t  sb[$];
  nrow_t tbl[6];
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic push_exp(string nm, int l, bit m, bit d, bit t, int n);
    exp_t e;
    e.nm = nm; e.lines = l; e.mov = m; e.done = d; e.tmo = t; e.nud = n;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    int   got_n;
    bit   bad;
    e     = sb.pop_front();
    got_n = int'($signed(nudge));
    bad   = (moving !== e.mov) || (move_done !== e.done) || (timeout !== e.tmo) ||
            (got_n != e.nud) || ((e.lines >= 0) && (int'(lines_crossed) != e.lines));
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got lines=%0d moving=%0b done=%0b timeout=%0b nudge=%0d; want lines=%0d moving=%0b done=%0b timeout=%0b nudge=%0d",
               e.nm, lines_crossed, moving, move_done, timeout, got_n,
               e.lines, e.mov, e.done, e.tmo, e.nud);
    end
  endtask

  // One clock edge with the currently driven inputs, then compare.
  task automatic step(string nm, int l, bit m, bit d, bit t, int n);
    push_exp(nm, l, m, d, t, n);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_n;

    tbl[0] = '{l: 1'b1, r: 1'b0, nd:  96, nh:  96};
    tbl[1] = '{l: 1'b0, r: 1'b1, nd: -96, nh: -96};
    tbl[2] = '{l: 1'b1, r: 1'b1, nd:   0, nh: -96};
    tbl[3] = '{l: 1'b0, r: 1'b0, nd:   0, nh: -96};
    tbl[4] = '{l: 1'b1, r: 1'b0, nd:  96, nh:  96};
    tbl[5] = '{l: 1'b0, r: 1'b0, nd:   0, nh:  96};

    // ---- reset state ----
    #3;
    push_exp("reset", 0, 0, 0, 0, 0);
    check_front();
    idle(2);
    rst_n = 1'b1;

    // ---- 3-square move: six crossings, settle, done ----
    num_sqrs = 3'd3; strt_move = 1'b1;
    step("mv3_start", 0, 1, 0, 0, 0);
    strt_move = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      idle(96);
      if (k == 3) begin
        strt_move = 1'b1; num_sqrs = 3'd1;
        step("mv3_strt_ignored", k - 1, 1, 0, 0, 0);
        strt_move = 1'b0;
      end
      cntrIR = 1'b1;
      step("mv3_rise", k, 1, 0, 0, 0);
      step("mv3_level_no_count", k, 1, 0, 0, 0);
      cntrIR = 1'b0;
    end
    for (int j = 2; j <= 15; j++) begin
      if (j == 5) cntrIR = 1'b1;
      if (j == 6) cntrIR = 1'b0;
      step("mv3_settle", 6, 1, 0, 0, 0);
    end
    step("mv3_done", 6, 0, 1, 0, 0);
    step("mv3_done_single", 6, 0, 0, 0, 0);

    // ---- zero-square move ----
    num_sqrs = 3'd0; strt_move = 1'b1;
    step("zero_done", -1, 0, 1, 0, 0);
    strt_move = 1'b0;
    step("zero_done_single", -1, 0, 0, 0, 0);

    // ---- nudge table inside a move ----
    num_sqrs = 3'd7; strt_move = 1'b1;
    step("nud_start", 0, 1, 0, 0, 0);
    strt_move = 1'b0;
    for (int i = 0; i < 6; i++) begin
      lftIR = tbl[i].l; rghtIR = tbl[i].r;
`ifdef IR_NUDGE_HOLD_EN
      exp_n = tbl[i].nh;
`else
      exp_n = tbl[i].nd;
`endif
      step("nud_table", 0, 1, 0, 0, exp_n);
    end
`ifdef IR_NUDGE_HOLD_EN
    lftIR = 1'b1; rghtIR = 1'b0;
    for (int i = 0; i < 10; i++) step("hold_pulse", 0, 1, 0, 0, 96);
    lftIR = 1'b0;
    for (int i = 0; i < 256; i++) step("hold_persist", 0, 1, 0, 0, 96);
    step("hold_expired", 0, 1, 0, 0, 0);
`endif
    lftIR = 1'b1; rghtIR = 1'b0; abort = 1'b1;
    step("nud_abort_zero", 0, 0, 0, 0, 0);
    abort = 1'b0;
    step("nud_idle_zero", 0, 0, 0, 0, 0);
    lftIR = 1'b0;

    // ---- abort coinciding with the final rise ----
    num_sqrs = 3'd1; strt_move = 1'b1;
    step("abt_start", 0, 1, 0, 0, 0);
    strt_move = 1'b0;
    idle(3);
    cntrIR = 1'b1;
    step("abt_rise1", 1, 1, 0, 0, 0);
    cntrIR = 1'b0;
    idle(3);
    cntrIR = 1'b1; abort = 1'b1;
    step("abt_wins", 1, 0, 0, 0, 0);
    cntrIR = 1'b0; abort = 1'b0;
    for (int i = 0; i < 20; i++) step("abt_no_done", 1, 0, 0, 0, 0);

    // ---- watchdog timeout ----
    num_sqrs = 3'd1; strt_move = 1'b1;
    step("tmo_start", 0, 1, 0, 0, 0);
    strt_move = 1'b0;
    idle(4);
    cntrIR = 1'b1;
    step("tmo_rise", 1, 1, 0, 0, 0);
    cntrIR = 1'b0;
    idle(1020);
    step("tmo_before", 1, 1, 0, 0, 0);
    step("tmo_edge_minus1", 1, 1, 0, 0, 0);
    step("tmo_fire", 1, 0, 0, 1, 0);
    step("tmo_sticky", 1, 0, 0, 1, 0);
    num_sqrs = 3'd2; strt_move = 1'b1;
    step("tmo_cleared", 0, 1, 0, 0, 0);
    strt_move = 1'b0;

    // ---- rise coinciding with watchdog expiry ----
    idle(1021);
    step("race_before", 0, 1, 0, 0, 0);
    cntrIR = 1'b1;
    step("race_rise_wins", 1, 1, 0, 0, 0);
    cntrIR = 1'b0;
    step("race_still_moving", 1, 1, 0, 0, 0);

    // ---- asynchronous reset mid-move ----
    idle(5);
    cntrIR = 1'b1;
    step("rst_rise2", 2, 1, 0, 0, 0);
    cntrIR = 1'b0;
    idle(5);
    cntrIR = 1'b1;
    step("rst_rise3", 3, 1, 0, 0, 0);
    cntrIR = 1'b0; lftIR = 1'b1;
    step("rst_nudge", 3, 1, 0, 0, 96);
    rst_n = 1'b0;
    #1;
    push_exp("rst_async", 0, 0, 0, 0, 0);
    check_front();
    lftIR = 1'b0;
    idle(1);
    rst_n = 1'b1;
    step("rst_released", 0, 0, 0, 0, 0);
    num_sqrs = 3'd1; strt_move = 1'b1;
    step("post_start", 0, 1, 0, 0, 0);
    strt_move = 1'b0;
    idle(3);
    cntrIR = 1'b1;
    step("post_rise1", 1, 1, 0, 0, 0);
    cntrIR = 1'b0;
    idle(3);
    cntrIR = 1'b1;
    step("post_rise2", 2, 1, 0, 0, 0);
    cntrIR = 1'b0;
    idle(15);
    step("post_done", 2, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
